// File: rtl/ram_pkg.sv
// Shared types and default parameters for the simple dual-port RAM slice.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps zero writes across the whole array, one word per cycle,
// and holds busy high while the sweep runs.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;

    // Reset lands in CLEAR so the array is always zeroed before first use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    addr_next  = '0;
                end
            end
            CLEAR: begin
                if (addr_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = addr_reg;

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM with byte enables, write-first same-address reads,
// 1- or 2-cycle read latency and a whole-array clear sweep.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [DATA_W-1:0]      data_out,
    output logic                   rd_valid,
    input  logic                   clr_req,
    output logic                   busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic wr_fire;
    logic rd_fire;
    logic same_addr;

    assign wr_fire   = we && !busy;
    assign rd_fire   = re && !busy;
    assign same_addr = (waddr == raddr);

    logic [DATA_W-1:0] rd_word;

    // One 8-bit array per byte lane so byte enables map onto plain write enables.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0]        mem [DEPTH];
            logic              lane_we;
            logic [ADDR_W-1:0] lane_addr;
            logic [7:0]        lane_wdata;
            logic [7:0]        rd_byte_reg;

            assign lane_we    = clr_we || (wr_fire && be[gi]);
            assign lane_addr  = clr_we ? clr_addr : waddr;
            assign lane_wdata = clr_we ? 8'h00 : data_in[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[lane_addr] <= lane_wdata;
                end
            end

            // Same-edge write to the read address bypasses the array (write-first).
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_byte_reg <= '0;
                end else if (rd_fire) begin
                    rd_byte_reg <= (wr_fire && be[gi] && same_addr) ?
                                   data_in[gi*8 +: 8] : mem[raddr];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    logic rd_pend_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg <= 1'b0;
        end else begin
            rd_pend_reg <= rd_fire;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] data_out_reg;
            logic              rd_valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_reg <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_pend_reg;
                    if (rd_pend_reg) begin
                        data_out_reg <= rd_word;
                    end
                end
            end

            assign data_out = data_out_reg;
            assign rd_valid = rd_valid_reg;
        end else begin : g_lat1
            assign data_out = rd_word;
            assign rd_valid = rd_pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp.sv
// Bench for ram_sdp: an 8-bit/RD_LAT=1 and a 16-bit/RD_LAT=2 instance share one
// stimulus stream and are both compared every cycle against a word-array model.
module tb_ram_sdp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, re, clr_req;
    logic [1:0]  be;
    logic [3:0]  waddr, raddr;
    logic [15:0] din;

    logic [7:0]  data_out_a;
    logic        rd_valid_a, busy_a;
    logic [15:0] data_out_b;
    logic        rd_valid_b, busy_b;

    ram_sdp #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .be(be[0:0]), .waddr(waddr),
        .data_in(din[7:0]), .re(re), .raddr(raddr), .data_out(data_out_a),
        .rd_valid(rd_valid_a), .clr_req(clr_req), .busy(busy_a)
    );

    ram_sdp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr),
        .data_in(din), .re(re), .raddr(raddr), .data_out(data_out_b),
        .rd_valid(rd_valid_b), .clr_req(clr_req), .busy(busy_b)
    );

    // Model index k: 0 = 8-bit word, latency 1; 1 = 16-bit word, latency 2.
    logic [15:0] m_mem   [2][16];
    logic        m_busy  [2];
    int          m_sweep [2];
    logic        m_v1    [2];
    logic [15:0] m_d1    [2];
    logic        m_vld   [2];
    logic [15:0] m_dout  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply one clock edge worth of behaviour to the model using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int          nb;
            logic [15:0] rdata;
            nb = k + 1;
            if (rst) begin
                m_busy[k]  = 1'b1;
                m_sweep[k] = 0;
                m_v1[k]    = 1'b0;
                m_d1[k]    = '0;
                m_vld[k]   = 1'b0;
                m_dout[k]  = '0;
            end else if (m_busy[k]) begin
                m_mem[k][m_sweep[k]] = '0;
                if (m_sweep[k] == 15) m_busy[k] = 1'b0;
                else                  m_sweep[k]++;
                if (k == 1) begin
                    m_vld[k] = m_v1[k];
                    if (m_v1[k]) m_dout[k] = m_d1[k];
                    m_v1[k] = 1'b0;
                end else begin
                    m_vld[k] = 1'b0;
                end
            end else begin
                if (we) begin
                    for (int b = 0; b < nb; b++) begin
                        if (be[b]) m_mem[k][waddr][8*b +: 8] = din[8*b +: 8];
                    end
                end
                rdata = m_mem[k][raddr];
                if (k == 0) begin
                    m_vld[k] = re;
                    if (re) m_dout[k] = rdata;
                end else begin
                    m_vld[k] = m_v1[k];
                    if (m_v1[k]) m_dout[k] = m_d1[k];
                    m_v1[k] = re;
                    if (re) m_d1[k] = rdata;
                end
                if (clr_req) begin
                    m_busy[k]  = 1'b1;
                    m_sweep[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        $display("cyc %0d rst=%b we=%b be=%b wa=%0d din=%h re=%b ra=%0d clr=%b | A busy=%b vld=%b dout=%h | B busy=%b vld=%b dout=%h",
                 cyc, rst, we, be, waddr, din, re, raddr, clr_req,
                 busy_a, rd_valid_a, data_out_a, busy_b, rd_valid_b, data_out_b);
        check("busy_a", busy_a, m_busy[0]);
        check("vld_a", rd_valid_a, m_vld[0]);
        check("dout_a", data_out_a, m_dout[0][7:0]);
        check("busy_b", busy_b, m_busy[1]);
        check("vld_b", rd_valid_b, m_vld[1]);
        check("dout_b", data_out_b, m_dout[1]);
    endtask

    // Counts cycles with busy high, starting from the current one; bounded.
    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check(tag, n, 16);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
            m_busy[k] = 1'b0; m_sweep[k] = 0; m_v1[k] = 1'b0;
            m_d1[k] = '0; m_vld[k] = 1'b0; m_dout[k] = '0;
        end
        rst = 1'b1; we = 1'b0; re = 1'b0; clr_req = 1'b0;
        be = '0; waddr = '0; raddr = '0; din = '0;
        @(negedge clk);
        tick();
        tick();

        // Power-up clear, then every address reads zero.
        rst = 1'b0;
        count_busy("busy_after_rst");
        re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr = 4'(i);
            tick();
        end
        re = 1'b0;
        tick();

        // Three writes then back-to-back reads.
        we = 1'b1; be = 2'b11;
        waddr = 4'd1; din = 16'd10; tick();
        waddr = 4'd2; din = 16'd20; tick();
        waddr = 4'd3; din = 16'd30; tick();
        we = 1'b0; re = 1'b1;
        raddr = 4'd1; tick(); check("rd_seq1_a", data_out_a, 8'd10);
        raddr = 4'd2; tick(); check("rd_seq2_a", data_out_a, 8'd20);
        raddr = 4'd3; tick(); check("rd_seq3_a", data_out_a, 8'd30);
        re = 1'b0; tick(); check("rd_seq3_b", data_out_b, 16'd30);

        // Byte-enable partial overwrite.
        we = 1'b1; be = 2'b11; waddr = 4'd5; din = 16'hABCD; tick();
        be = 2'b01; din = 16'h1234; tick();
        we = 1'b0; re = 1'b1; raddr = 4'd5; tick();
        check("be_merge_a", data_out_a, 8'h34);
        re = 1'b0; tick();
        check("be_merge_b", data_out_b, 16'hAB34);

        // Same-edge write and read of one address returns the new data.
        we = 1'b1; be = 2'b11; waddr = 4'd7; din = 16'h0055; re = 1'b1; raddr = 4'd7; tick();
        check("wr_first_a", data_out_a, 8'h55);
        we = 1'b0; re = 1'b0; tick();
        check("wr_first_b", data_out_b, 16'h0055);

        // Clear while reads are requested every cycle.
        re = 1'b1; raddr = 4'd3; clr_req = 1'b1; tick();
        clr_req = 1'b0;
        count_busy("busy_clr");
        tick();
        check("after_clr_vld_a", rd_valid_a, 1'b1);
        check("after_clr_a", data_out_a, 8'h00);
        re = 1'b0; tick();

        // Reset in the middle of a clear sweep restarts it.
        we = 1'b1; be = 2'b11; waddr = 4'd9; din = 16'hBEEF; tick();
        we = 1'b0; clr_req = 1'b1; re = 1'b1; raddr = 4'd9; tick();
        clr_req = 1'b0;
        for (int i = 0; i < 20 && m_sweep[1] != 9; i++) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        count_busy("busy_rst_mid_clr");
        tick();
        check("rst_mid_clr_b", data_out_b, 16'h0000);
        re = 1'b0;

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 300; i++) begin
            we      = 1'($urandom_range(0, 1));
            re      = 1'($urandom_range(0, 1));
            be      = 2'($urandom_range(0, 3));
            waddr   = 4'($urandom_range(0, 15));
            raddr   = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            din     = 16'($urandom_range(0, 65535));
            clr_req = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; we = 1'b0; re = 1'b0; clr_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp.md
RAM_SDP -- requirements
Module: ram_sdp

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 Derived constant BE_W = DATA_W/8, byte-enable width.
REQ-005 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset, synchronous and active-high.
REQ-007 Port we, input, 1, write strobe.
REQ-008 Port be, input, BE_W, byte enables qualifying we; bit i covers data_in[8i+7:8i].
REQ-009 Port waddr, input, ADDR_W, write address.
REQ-010 Port data_in, input, DATA_W, write data.
REQ-011 Port re, input, 1, read strobe.
REQ-012 Port raddr, input, ADDR_W, read address.
REQ-013 Port data_out, output, DATA_W, registered read data.
REQ-014 Port rd_valid, output, 1, data_out holds the result of a read this cycle.
REQ-015 Port clr_req, input, 1, single-cycle request to zero the whole array.
REQ-016 Port busy, output, 1, clear sweep in progress; accesses are not accepted while high.

Function
REQ-017 Simple dual-port: one write and one read SHALL be accepted in the same cycle when busy=0.
REQ-018 Write: at an edge with we=1 and busy=0, bytes of mem[waddr] with be[i]=1 SHALL take data_in; bytes with be[i]=0 SHALL be unchanged.
REQ-019 Read: at edge N with re=1 and busy=0, data_out SHALL show mem[raddr] and rd_valid=1 after edge N+RD_LAT-1; otherwise rd_valid SHALL be 0 at that point.
REQ-020 data_out SHALL hold its last value when rd_valid=0.
REQ-021 Read and write of the same address at the same edge SHALL return the new data: enabled bytes from data_in, other bytes from old contents (write-first).
REQ-022 With RD_LAT=2, read requests SHALL be fully pipelined: back-to-back re gives back-to-back rd_valid in the same order.
REQ-023 The clear FSM has states IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after the write at address DEPTH-1.
REQ-024 In CLEAR, each edge SHALL write zero to the sweep address and increment it; busy SHALL be 1 for exactly DEPTH cycles.
REQ-025 we, re and clr_req SHALL be ignored while busy=1; reads already in the pipeline SHALL complete with the data captured at issue.
REQ-026 At an IDLE edge with we=1 and clr_req=1, the write SHALL occur and the clear then starts; the clear overwrites the written value.
REQ-027 The sweep address SHALL not wrap past DEPTH-1; ADDR_W-bit addresses need no range check.

Reset
REQ-028 rst=1 at an edge SHALL set data_out=0, rd_valid=0 and the read pipeline empty, enter CLEAR with sweep address 0, and set busy=1.
REQ-029 After rst falls, busy SHALL remain 1 for DEPTH cycles while the array is zeroed; a reset during CLEAR restarts the sweep at address 0.
REQ-030 Memory contents SHALL be defined (all zero) only once busy first falls after reset.

Structure
REQ-031 Package ram_pkg SHALL hold the clear FSM state enum (IDLE, CLEAR) and the default DATA_W/ADDR_W/RD_LAT constants.
REQ-032 Sub-module ram_clear_seq SHALL contain the clear FSM and the sweep counter, with outputs busy, clr_we and clr_addr; ram_sdp instantiates it once.

Verification
REQ-033 Reset then idle for 16 cycles (defaults) -> busy high for exactly 16 cycles; re at addresses 0..15 then returns 0, rd_valid one cycle after each re.
REQ-034 Write 10,20,30 to addresses 1,2,3 with be=1, then read 1,2,3 back-to-back -> data_out 10,20,30 on consecutive cycles with rd_valid=1.
REQ-035 DATA_W=16: write 0xABCD to address 5, then write 0x1234 with be=2'b01 -> read returns 0xAB34.
REQ-036 Same-edge write 0x55 and read of address 7 -> data_out=0x55 (write-first).
REQ-037 clr_req pulsed while re is asserted on every cycle -> re is ignored for 16 cycles (rd_valid low), then address 3 reads 0.
REQ-038 RD_LAT=2, rst asserted during a clear at sweep address 9 -> sweep restarts at address 0; busy high for 16 cycles after rst falls; rd_valid stays 0 throughout.
